uart_tx: RTL and testbench

Serial UART transmitter: 8N1 framing, LSB first, fixed baud from a clock-count parameter. A 4-entry byte FIFO sits in front of the serializer behind a valid/ready handshake, so the host can queue bytes while a frame is on the line. Sits on the same `clk` domain as the UART receiver and drives the board TX pin directly. Consecutive queued bytes go out with no idle gap.

---
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, with a small byte FIFO in front of the
// serializer so the host can queue bytes while a frame is on the line.
module uart_tx #(
  parameter logic [13:0] CLOCKS_PER_BAUD = 14'd868,
  parameter int unsigned FIFO_AW         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  localparam logic [FIFO_AW:0]   DEPTH_C     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ZERO_C  = {(FIFO_AW + 1){1'b0}};
  localparam logic [FIFO_AW:0]   CNT_ONE_C   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO_C  = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE_C   = FIFO_AW'(1);
  localparam logic [13:0]        BAUD_LAST_C = CLOCKS_PER_BAUD - 14'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [7:0]         mem_r [(1 << FIFO_AW)];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [13:0]        baud_cnt_r, baud_cnt_s;
  logic [2:0]         bit_idx_r, bit_idx_s;
  logic [7:0]         shift_r, shift_s;
  logic               tx_out_s;
  logic               push_s, pop_s, bit_end_s, fifo_nempty_s;

  assign tx_ready      = (count_r != DEPTH_C);
  assign push_s        = tx_valid && tx_ready;
  assign bit_end_s     = (baud_cnt_r == 14'd0);
  assign fifo_nempty_s = (count_r != CNT_ZERO_C);
  assign busy          = (state_r != IDLE) || fifo_nempty_s;

  // FIFO storage: plain registers, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer: next state, baud/bit counters, shifter and next line level
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    tx_out_s   = tx_out;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        tx_out_s = 1'b1;
        if (fifo_nempty_s) begin
          pop_s      = 1'b1;
          shift_s    = mem_r[rd_ptr_r];
          baud_cnt_s = BAUD_LAST_C;
          state_s    = START;
          tx_out_s   = 1'b0;
        end else begin
          baud_cnt_s = BAUD_LAST_C;
        end
      end
      START: begin
        tx_out_s = 1'b0;
        if (bit_end_s) begin
          state_s    = DATA;
          bit_idx_s  = 3'd0;
          baud_cnt_s = BAUD_LAST_C;
          tx_out_s   = shift_r[0];
        end else begin
          baud_cnt_s = baud_cnt_r - 14'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = BAUD_LAST_C;
          shift_s    = {1'b0, shift_r[7:1]};
          bit_idx_s  = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s  = STOP;
            tx_out_s = 1'b1;
          end else begin
            tx_out_s = shift_r[1];
          end
        end else begin
          baud_cnt_s = baud_cnt_r - 14'd1;
        end
      end
      STOP: begin
        tx_out_s = 1'b1;
        if (bit_end_s) begin
          baud_cnt_s = BAUD_LAST_C;
          // Next byte starts on the very edge the stop bit ends: no idle gap
          if (fifo_nempty_s) begin
            pop_s    = 1'b1;
            shift_s  = mem_r[rd_ptr_r];
            state_s  = START;
            tx_out_s = 1'b0;
          end else begin
            state_s  = IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r - 14'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        baud_cnt_s = BAUD_LAST_C;
        tx_out_s   = 1'b1;
      end
    endcase
  end

  // Sequencer registers; the line flop resets high so TX idles the instant reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_LAST_C;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_out     <= 1'b1;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      tx_out     <= tx_out_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes every frame of the CPB=4
// instance against a queue of accepted bytes; a CPB=2 instance covers the short-bit boundary.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       tx_out, tx_out2;
  logic       busy, busy2;
  int         cyc;

  uart_tx #(.CLOCKS_PER_BAUD(14'd4), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy)
  );

  uart_tx #(.CLOCKS_PER_BAUD(14'd2), .FIFO_AW(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tests;
  int         fails;
  int         frames_done;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         fall_lat;
    int         busy_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push one byte, waiting for tx_ready; returns the accepting edge number. Leaves tx_valid high.
  task automatic push_byte(input logic [7:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", (n < 1000) ? 1 : 0, 1);
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic wait_low(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_out !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
  endtask

  task automatic wait_idle(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
  endtask

  // Line monitor: every cycle of every frame must match the expected start/data/stop level
  initial begin : mon
    logic       active;
    logic       spur;
    logic [9:0] frame;
    int         pos;
    int         bad;
    active = 1'b0;
    spur   = 1'b0;
    frame  = 10'h3FF;
    pos    = 0;
    bad    = 0;
    frames_done = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        active = 1'b0;
      end else begin
        if (!active && tx_out === 1'b0) begin
          active = 1'b1;
          pos    = 0;
          bad    = 0;
          if (exp_q.size() == 0) begin
            spur = 1'b1;
            check("unexpected_frame", 1, 0);
          end else begin
            spur  = 1'b0;
            frame = {1'b1, exp_q.pop_front(), 1'b0};
          end
        end
        if (active) begin
          if (tx_out !== frame[pos / CPB]) bad++;
          pos++;
          if (pos == 10 * CPB) begin
            active = 1'b0;
            if (!spur) begin
              check("frame_bits", bad, 0);
              frames_done++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0, c, bad;
    int         acc[6];
    logic [9:0] frame2;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'h55, 1, 1 + 10 * CPB};
    vecs[1] = '{8'h00, 1, 1 + 10 * CPB};
    vecs[2] = '{8'hFF, 1, 1 + 10 * CPB};
    vecs[3] = '{8'hA5, 1, 1 + 10 * CPB};
    vecs[4] = '{8'h3C, 1, 1 + 10 * CPB};
    vecs[5] = '{8'h81, 1, 1 + 10 * CPB};

    reset     = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_out2", tx_out2, 1);
    check("rst_busy2", busy2, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single bytes: start latency, frame content (monitor), busy drop, line stays idle
    for (int i = 0; i < 6; i++) begin
      push_byte(vecs[i].data, n0);
      tx_valid = 1'b0;
      wait_low(c);
      check("fall_latency", c - n0, vecs[i].fall_lat);
      wait_idle(c);
      check("busy_latency", c - n0, vecs[i].busy_lat);
      repeat (3) @(negedge clk);
      check("idle_tx_out", tx_out, 1);
      check("idle_busy", busy, 0);
    end
    check("frames_after_table", frames_done, 6);

    // FIFO full: 0x01 popped at once, four more queued, 0x06 held until the first pop
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(i + 1), acc[i]);
      check("full_accept_edge", acc[i] - acc[0], i);
    end
    check("full_ready_low", tx_ready, 0);
    check("full_count", dut.count_r, 4);
    push_byte(8'h06, acc[5]);
    tx_valid = 1'b0;
    check("held_byte_edge", acc[5] - acc[0], 42);
    wait_idle(c);
    check("six_frame_span", c - acc[0], 1 + 6 * 10 * CPB);
    check("frames_after_full", frames_done, 12);

    // Push on the edge that ends a stop bit while count==3
    repeat (2) @(negedge clk);
    push_byte(8'hC1, acc[0]);
    push_byte(8'hC2, acc[1]);
    push_byte(8'hC3, acc[2]);
    push_byte(8'hC4, acc[3]);
    tx_valid = 1'b0;
    while (cyc < acc[0] + 10 * CPB) @(negedge clk);
    check("sim_count_before", dut.count_r, 3);
    tx_data  = 8'hE7;
    tx_valid = 1'b1;
    check("sim_ready", tx_ready, 1);
    exp_q.push_back(8'hE7);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check("sim_count_after", dut.count_r, 3);
    check("sim_start_bit", tx_out, 0);
    wait_idle(c);
    check("sim_span", c - acc[0], 1 + 5 * 10 * CPB);
    check("frames_after_sim", frames_done, 17);
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset during bit 3 of 0xAA with two bytes queued
    push_byte(8'hAA, n0);
    push_byte(8'h11, c);
    push_byte(8'h22, c);
    tx_valid = 1'b0;
    while (cyc < n0 + 1 + 4 * CPB + 1) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_tx_out", tx_out, 1);
    check("async_rst_ready", tx_ready, 1);
    check("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("quiet_after_reset", bad, 0);
    check("count_after_reset", dut.count_r, 0);

    // Boundary: two-cycle bits on the CPB=2 instance, 0x80
    frame2 = {1'b1, 8'h80, 1'b0};
    @(negedge clk);
    tx_data2  = 8'h80;
    tx_valid2 = 1'b1;
    check("b2_ready", tx_ready2, 1);
    @(posedge clk);
    #1;
    tx_valid2 = 1'b0;
    @(negedge clk);
    check("b2_not_yet", tx_out2, 1);
    bad = 0;
    for (int k = 0; k < 10 * CPB2; k++) begin
      @(negedge clk);
      if (tx_out2 !== frame2[k / CPB2] || busy2 !== 1'b1) bad++;
    end
    check("b2_frame_bits", bad, 0);
    @(negedge clk);
    check("b2_end_tx_out", tx_out2, 1);
    check("b2_end_busy", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
